// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared loader state encodings and imem geometry.
package imem_loader_pkg;
  localparam int IMEM_ADDR_W = 5;
  typedef enum logic [2:0] {
    LD_IDLE,
    LD_HDR_HI,
    LD_HDR_LO,
    LD_DATA,
    LD_LAST,
    LD_RUN,
    LD_ERR
  } ld_state_e;
endpackage

// File: rtl/imem_loader_word_packer.sv
// imem_word_packer: packs accepted bytes MSB-first into 32-bit words.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  data_in,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0]  idx_q;
  logic [23:0] sr_q;
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      idx_q <= '0;
      sr_q  <= '0;
    end else if (byte_en) begin
      idx_q <= idx_q + 2'd1;
      sr_q  <= {sr_q[15:0], data_in};
    end
  end
  // The 4th byte completes the word combinationally; the top registers it.
  assign word_valid = byte_en && idx_q == 2'd3;
  assign word       = {sr_q, data_in};
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed byte image into imem, holding the CPU in reset until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reload,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error
);
  localparam int DEPTH = 2 ** ADDR_W;
  ld_state_e         state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d, addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              in_ready_q, in_ready_d, we_q, we_d, cpu_q, cpu_d, done_q, done_d, err_q, err_d;
  logic              accept, word_valid, last_word;
  logic [31:0]       word;
  logic [15:0]       n_hdr;
  assign accept    = in_valid && in_ready_q;
  assign n_hdr     = {cnt_q[15:8], in_data};
  assign last_word = 16'(idx_q) == cnt_q - 16'd1;
  // Any partial word is dropped whenever the loader is not actively in DATA.
  imem_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (reload || state_q != LD_DATA),
    .byte_en   (accept && state_q == LD_DATA),
    .data_in   (in_data),
    .word_valid(word_valid),
    .word      (word)
  );
  always_ff @(posedge clk) begin
    if (!rst_n || reload) begin
      state_q    <= LD_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      cpu_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      cpu_q      <= cpu_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE:   state_d = LD_HDR_HI;
      LD_HDR_HI: state_d = accept ? LD_HDR_LO : LD_HDR_HI;
      LD_HDR_LO: state_d = !accept ? LD_HDR_LO : n_hdr > 16'(DEPTH) ? LD_ERR :
                           n_hdr == 16'd0 ? LD_LAST : LD_DATA;
      LD_DATA:   state_d = word_valid && last_word ? LD_LAST : LD_DATA;
      LD_LAST:   state_d = LD_RUN;
      default:   state_d = state_q;
    endcase
  end
  always_comb begin
    cnt_d      = accept && state_q == LD_HDR_HI ? {in_data, 8'h00} :
                 accept && state_q == LD_HDR_LO ? n_hdr : cnt_q;
    in_ready_d = state_q == LD_IDLE ||
                 (in_ready_q && state_d inside {LD_HDR_HI, LD_HDR_LO, LD_DATA});
    we_d       = word_valid;
    addr_d     = word_valid ? idx_q : addr_q;
    wdata_d    = word_valid ? word : wdata_q;
    idx_d      = idx_q + ADDR_W'(word_valid);
    cpu_d      = state_d == LD_RUN;
    done_d     = state_d == LD_RUN;
    err_d      = state_d == LD_ERR;
  end
  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst_n  = cpu_q;
  assign done       = done_q;
  assign error      = err_q;
endmodule
